noc_local_inject_arbiter: RTL and testbench

// - Parametrised successor to the fixed 2-channel per-node receive front end of the NoC fabric.
// - Buffers NUM_CH local injection channels in per-channel FIFOs.
// - Arbitrates round-robin at packet granularity: a grant is held from header to tail.
// - Drives a single registered sender port toward the router. One instance per mesh node.

---
 rtl/noc_local_inject_arbiter.sv | 165 ++++++++++++++++
 tb/tb_noc_local_inject_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_local_inject_arbiter.sv
// Per-node NoC injection front end: per-channel FIFOs, packet-atomic round-robin
// arbitration, registered sender port. Optional per-channel flit counters: NOC_FLIT_CNT_EN.
module noc_local_inject_arbiter #(
    parameter int NUM_CH     = 2,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int VC_THRESH  = 2
) (
    input  logic                     noc_clk,
    input  logic                     noc_rst_n,
    input  logic [NUM_CH-1:0]        rx_valid,
    output logic [NUM_CH-1:0]        rx_ready,
    input  logic [NUM_CH*DATA_W-1:0] rx_flit,
    input  logic [NUM_CH-1:0]        rx_is_header,
    input  logic [NUM_CH-1:0]        rx_is_tail,
    output logic [NUM_CH-1:0]        rx_vc_ready,
    output logic                     tx_valid,
    input  logic                     tx_ready,
    output logic [DATA_W-1:0]        tx_flit,
    output logic                     tx_is_header,
    output logic                     tx_is_tail,
    input  logic                     tx_vc_ready,
`ifdef NOC_FLIT_CNT_EN
    output logic [NUM_CH*32-1:0]     flit_cnt,
`endif
    output logic                     err_drop
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int RW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int EW = DATA_W + 2;

    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] THR_C   = CW'(VC_THRESH);

    typedef enum logic {
        IDLE,
        XFER
    } state_t;

    state_t                     state;
    logic [RW-1:0]              rr;
    logic [RW-1:0]              gnt;
    logic [RW-1:0]              sel;
    logic [RW-1:0]              src;
    logic                       found;
    logic                       slot_free;
    logic                       gnt_go;
    logic                       xfer_go;
    logic                       mv;
    logic [NUM_CH-1:0][EW-1:0]  head;
    logic [NUM_CH-1:0]          nonempty;
    logic [NUM_CH-1:0]          head_hdr;
    logic [NUM_CH-1:0]          head_tail;
    logic [NUM_CH-1:0]          cand;
    logic [NUM_CH-1:0]          drop;
    logic [NUM_CH-1:0]          fwd;
    logic [NUM_CH-1:0]          push;
    logic [NUM_CH-1:0]          pop;

    // Per-channel circular FIFO; entry = {header, tail, flit}
    for (genvar c = 0; c < NUM_CH; c++) begin : g_fifo
        logic [EW-1:0] mem [FIFO_DEPTH];
        logic [PW-1:0] wr_ptr;
        logic [PW-1:0] rd_ptr;
        logic [CW-1:0] cnt;

        assign head[c]        = mem[rd_ptr];
        assign nonempty[c]    = (cnt != '0);
        assign head_hdr[c]    = head[c][EW-1];
        assign head_tail[c]   = head[c][EW-2];
        assign rx_ready[c]    = (cnt != DEPTH_C);
        assign rx_vc_ready[c] = ((DEPTH_C - cnt) >= THR_C);
        assign push[c]        = rx_valid[c] & rx_ready[c];

        always_ff @(posedge noc_clk) begin
            if (push[c]) begin
                mem[wr_ptr] <= {rx_is_header[c], rx_is_tail[c],
                                rx_flit[c*DATA_W +: DATA_W]};
            end
        end

        always_ff @(posedge noc_clk or negedge noc_rst_n) begin
            if (!noc_rst_n) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                cnt    <= '0;
            end else begin
                if (push[c]) wr_ptr <= wr_ptr + PW'(1);
                if (pop[c])  rd_ptr <= rd_ptr + PW'(1);
                case ({push[c], pop[c]})
                    2'b10:   cnt <= cnt + CW'(1);
                    2'b01:   cnt <= cnt - CW'(1);
                    default: cnt <= cnt;
                endcase
            end
        end
    end

    assign cand = nonempty & head_hdr;
    assign drop = (state == IDLE) ? (nonempty & ~head_hdr) : '0;

    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!found && cand[(int'(rr) + i) % NUM_CH]) begin
                found = 1'b1;
                sel   = RW'((int'(rr) + i) % NUM_CH);
            end
        end
    end

    assign slot_free = !tx_valid || tx_ready;
    assign gnt_go    = (state == IDLE) && found && tx_vc_ready && slot_free;
    assign xfer_go   = (state == XFER) && nonempty[gnt] && slot_free;
    assign mv        = gnt_go || xfer_go;
    assign src       = (state == XFER) ? gnt : sel;
    assign fwd       = mv ? (NUM_CH'(1) << src) : '0;
    assign pop       = fwd | drop;

    always_ff @(posedge noc_clk or negedge noc_rst_n) begin
        if (!noc_rst_n) begin
            state        <= IDLE;
            rr           <= '0;
            gnt          <= '0;
            tx_valid     <= 1'b0;
            tx_flit      <= '0;
            tx_is_header <= 1'b0;
            tx_is_tail   <= 1'b0;
            err_drop     <= 1'b0;
        end else begin
            err_drop <= |drop;
            if (mv) begin
                tx_valid     <= 1'b1;
                tx_flit      <= head[src][DATA_W-1:0];
                tx_is_header <= head_hdr[src];
                tx_is_tail   <= head_tail[src];
                if (head_tail[src]) begin
                    state <= IDLE;
                    rr    <= (int'(src) == NUM_CH - 1) ? '0 : src + RW'(1);
                end else begin
                    state <= XFER;
                    gnt   <= src;
                end
            end else if (slot_free) begin
                tx_valid <= 1'b0;
            end
        end
    end

`ifdef NOC_FLIT_CNT_EN
    always_ff @(posedge noc_clk or negedge noc_rst_n) begin
        if (!noc_rst_n) begin
            flit_cnt <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (fwd[c]) flit_cnt[c*32 +: 32] <= flit_cnt[c*32 +: 32] + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_noc_local_inject_arbiter.sv
// Directed scoreboard bench for noc_local_inject_arbiter (default parameters).
module tb_noc_local_inject_arbiter;

    localparam int NCH = 2;
    localparam int DW  = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NCH-1:0]    rx_valid = '0;
    logic [NCH-1:0]    rx_ready;
    logic [NCH*DW-1:0] rx_flit = '0;
    logic [NCH-1:0]    rx_is_header = '0;
    logic [NCH-1:0]    rx_is_tail = '0;
    logic [NCH-1:0]    rx_vc_ready;
    logic              tx_valid;
    logic              tx_ready = 1'b1;
    logic [DW-1:0]     tx_flit;
    logic              tx_is_header;
    logic              tx_is_tail;
    logic              tx_vc_ready = 1'b1;
    logic              err_drop;
`ifdef NOC_FLIT_CNT_EN
    logic [NCH*32-1:0] flit_cnt;
`endif

    int checks = 0;
    int failures = 0;
    int drop_cnt = 0;
    logic [33:0] exp_q[$];

    noc_local_inject_arbiter #(
        .NUM_CH(NCH), .DATA_W(DW), .FIFO_DEPTH(4), .VC_THRESH(2)
    ) dut (
        .noc_clk(clk),
        .noc_rst_n(rst_n),
        .rx_valid(rx_valid),
        .rx_ready(rx_ready),
        .rx_flit(rx_flit),
        .rx_is_header(rx_is_header),
        .rx_is_tail(rx_is_tail),
        .rx_vc_ready(rx_vc_ready),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .tx_flit(tx_flit),
        .tx_is_header(tx_is_header),
        .tx_is_tail(tx_is_tail),
        .tx_vc_ready(tx_vc_ready),
`ifdef NOC_FLIT_CNT_EN
        .flit_cnt(flit_cnt),
`endif
        .err_drop(err_drop)
    );

    always #5 clk = ~clk;

    function automatic logic [33:0] mk(input logic h, input logic t,
                                       input logic [31:0] d);
        return {h, t, d};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock: sample tx handshake / err_drop at negedge, return at posedge+1
    task automatic cyc();
        @(negedge clk);
        if (err_drop) drop_cnt++;
        if (tx_valid && tx_ready) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                failures++;
                $error("FAIL tx_unexpected got=%0h exp=none",
                       {tx_is_header, tx_is_tail, tx_flit});
            end
            if (exp_q.size() != 0)
                chk("tx_flit", {30'd0, tx_is_header, tx_is_tail, tx_flit},
                    {30'd0, exp_q.pop_front()});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int ch, input logic h, input logic t,
                         input logic [31:0] d);
        rx_valid[ch]       = 1'b1;
        rx_is_header[ch]   = h;
        rx_is_tail[ch]     = t;
        rx_flit[ch*DW +: DW] = d;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            cyc();
            n++;
        end
        checks++;
        assert (exp_q.size() == 0) else begin
            failures++;
            $error("FAIL drain_timeout left=%0d exp=0", exp_q.size());
        end
        exp_q.delete();
        cyc();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_rx_ready", 64'(rx_ready), 64'h3);
        chk("rst_vc_ready", 64'(rx_vc_ready), 64'h3);
        chk("rst_tx", {tx_valid, tx_is_header, tx_is_tail, tx_flit, err_drop}, 64'h0);

        // Simultaneous packets with rr=0: ch0 packet then ch1 packet
        for (int i = 0; i < 3; i++) exp_q.push_back(mk(i == 0, i == 2, 32'h100 + i));
        for (int i = 0; i < 3; i++) exp_q.push_back(mk(i == 0, i == 2, 32'h200 + i));
        for (int i = 0; i < 3; i++) begin
            drive(0, i == 0, i == 2, 32'h100 + i);
            drive(1, i == 0, i == 2, 32'h200 + i);
            cyc();
        end
        rx_valid = '0;
        drain(40);

        // Fill ch0 with VC gated, then stall the sender mid-packet
        tx_vc_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(0, i == 0, 1'b0, 32'h300 + i);
            exp_q.push_back(mk(i == 0, 1'b0, 32'h300 + i));
            cyc();
            if (i == 1) chk("vc_ready_after2", 64'(rx_vc_ready[0]), 64'h1);
            if (i == 2) begin
                chk("vc_ready_after3", 64'(rx_vc_ready[0]), 64'h0);
                chk("rx_ready_after3", 64'(rx_ready[0]), 64'h1);
            end
        end
        chk("rx_ready_full", 64'(rx_ready[0]), 64'h0);
        drive(0, 1'b0, 1'b0, 32'h3FF);
        cyc();
        rx_valid = '0;
        cyc();
        chk("vc_gate_no_tx", 64'(tx_valid), 64'h0);
        tx_vc_ready = 1'b1;
        cyc();
        chk("vc_open_hdr", {tx_valid, tx_is_header, tx_flit}, {30'd0, 2'b11, 32'h300});
        cyc();
        tx_ready = 1'b0;
        chk("stall_rx_ready", 64'(rx_ready[0]), 64'h1);
        drive(0, 1'b0, 1'b1, 32'h304);
        exp_q.push_back(mk(1'b0, 1'b1, 32'h304));
        for (int i = 0; i < 5; i++) begin
            chk("stall_hold", {tx_valid, tx_flit}, {31'd0, 1'b1, 32'h301});
            cyc();
            rx_valid = '0;
        end
        tx_ready = 1'b1;
        drain(40);

        // rr now points at ch1: second simultaneous pair starts with ch1
        for (int i = 0; i < 3; i++) exp_q.push_back(mk(i == 0, i == 2, 32'h500 + i));
        for (int i = 0; i < 3; i++) exp_q.push_back(mk(i == 0, i == 2, 32'h400 + i));
        for (int i = 0; i < 3; i++) begin
            drive(0, i == 0, i == 2, 32'h400 + i);
            drive(1, i == 0, i == 2, 32'h500 + i);
            cyc();
        end
        rx_valid = '0;
        drain(40);

        // Orphan body flit on idle ch1
        drop_cnt = 0;
        drive(1, 1'b0, 1'b0, 32'h666);
        cyc();
        rx_valid = '0;
        repeat (5) cyc();
        chk("orphan_drop_pulses", 64'(drop_cnt), 64'h1);
        chk("orphan_fifo_empty", 64'(rx_vc_ready), 64'h3);

        // Single-flit packet latency
        drive(0, 1'b1, 1'b1, 32'hA5);
        exp_q.push_back(mk(1'b1, 1'b1, 32'hA5));
        cyc();
        rx_valid = '0;
        chk("lat_edge1", 64'(tx_valid), 64'h0);
        cyc();
        chk("lat_edge2", {tx_valid, tx_is_header, tx_is_tail, tx_flit},
            {29'd0, 3'b111, 32'hA5});
        cyc();
        chk("single_idle", 64'(tx_valid), 64'h0);
        drive(1, 1'b1, 1'b1, 32'h5A);
        exp_q.push_back(mk(1'b1, 1'b1, 32'h5A));
        cyc();
        rx_valid = '0;
        drain(20);

        // Reset mid-packet discards buffered and in-flight flits
        tx_ready = 1'b0;
        drive(0, 1'b1, 1'b0, 32'h700);
        cyc();
        drive(0, 1'b0, 1'b0, 32'h701);
        cyc();
        rx_valid = '0;
        cyc();
        chk("inflight_valid", 64'(tx_valid), 64'h1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_tx", {tx_valid, tx_flit}, 64'h0);
        cyc();
        rst_n = 1'b1;
        tx_ready = 1'b1;
        chk("rst2_rx_ready", 64'(rx_ready), 64'h3);
        chk("rst2_vc_ready", 64'(rx_vc_ready), 64'h3);
        repeat (4) cyc();
        chk("rst2_no_tx", 64'(tx_valid), 64'h0);

`ifdef NOC_FLIT_CNT_EN
        chk("cnt_reset", flit_cnt, 64'h0);
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 3; i++) begin
                drive(1, i == 0, i == 2, 32'h800 + 16 * p + i);
                exp_q.push_back(mk(i == 0, i == 2, 32'h800 + 16 * p + i));
                cyc();
            end
        end
        rx_valid = '0;
        drain(40);
        chk("cnt_ch1", 64'(flit_cnt[63:32]), 64'd6);
        chk("cnt_ch0", 64'(flit_cnt[31:0]), 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
